// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: controller state encodings and stall-group bit positions.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, LD_WAIT = 2'd1, EX_BUSY = 2'd2, FLUSH = 2'd3} ctrl_state_e;
   localparam int SG_IF  = 0;
   localparam int SG_ID  = 1;
   localparam int SG_EX  = 2;
   localparam int SG_MEM = 3;
   localparam int SG_W   = 4;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: wrapping event counter with synchronous clear over increment.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else if (clr) cnt_q <= '0;
      else if (inc) cnt_q <= cnt_q + 1'b1;
   assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall/bubble/flush sequencing with perf counters.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LD_TIMEOUT = 256,
   parameter int FLUSH_LEN  = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             operands_valid,
   input  logic             exec_start,
   input  logic             exec_done,
   input  logic             branch_redirect,
   input  logic             trap_req,
   input  logic             cnt_clr,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             bubble_mem,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [1:0]       ctrl_state,
   output logic             ld_timeout,
   output logic [CNT_W-1:0] ld_stall_cnt,
   output logic [CNT_W-1:0] ex_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WW = $clog2(LD_TIMEOUT);
   localparam int FW = $clog2(FLUSH_LEN + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(LD_TIMEOUT - 1);
   localparam logic [FW-1:0] FL_RELOAD = FW'(FLUSH_LEN - 1);
   localparam ctrl_state_e FLUSH_NXT = (FLUSH_LEN > 1) ? FLUSH : RUN;

   ctrl_state_e state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [FW-1:0] fl_q, fl_d;
   logic to_q, to_d;
   logic flush_ev, ld_stall, ex_stall, ex_go;
   logic [SG_W-1:0] sg;

   // branch_redirect cannot preempt a multicycle op; only a trap can
   assign flush_ev = (state_q != FLUSH) && (trap_req || (branch_redirect && state_q != EX_BUSY));
   assign ex_go    = exec_start && !exec_done;
   assign ld_stall = !flush_ev && (state_q == RUN || state_q == LD_WAIT) && !operands_valid;
   assign ex_stall = !flush_ev && ((state_q == RUN && operands_valid && ex_go) ||
                                   (state_q == EX_BUSY && !exec_done));

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      fl_d    = fl_q;
      if (flush_ev) begin
         state_d = FLUSH_NXT;
         fl_d    = FL_RELOAD;
      end else begin
         case (state_q)
            RUN:     state_d = !operands_valid ? LD_WAIT : ex_go ? EX_BUSY : RUN;
            LD_WAIT: if (!operands_valid) wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                     else state_d = ex_go ? EX_BUSY : RUN;
            EX_BUSY: state_d = exec_done ? RUN : EX_BUSY;
            default: begin
               fl_d    = trap_req ? FL_RELOAD : fl_q - 1'b1;
               state_d = (!trap_req && fl_q <= FW'(1)) ? RUN : FLUSH;
            end
         endcase
      end
      to_d = (wait_d == WAIT_MAX) && (wait_q != WAIT_MAX);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         fl_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fl_q    <= fl_d;
         to_q    <= to_d;
      end

   assign sg         = {SG_W{(ld_stall || ex_stall) && !rst}};
   assign stall_if   = sg[SG_IF];
   assign stall_id   = sg[SG_ID];
   assign stall_ex   = sg[SG_EX];
   assign bubble_mem = sg[SG_MEM];
   assign flush_id   = (flush_ev || state_q == FLUSH) && !rst;
   assign flush_ex   = flush_id;
   assign ctrl_state = state_q;
   assign ld_timeout = to_q;

   perf_counter #(.CNT_W(CNT_W)) u_ld_cnt (.clk(clk), .rst(rst), .inc(ld_stall), .clr(cnt_clr), .cnt(ld_stall_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_ex_cnt (.clk(clk), .rst(rst), .inc(ex_stall), .clr(cnt_clr), .cnt(ex_stall_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_fl_cnt (.clk(clk), .rst(rst), .inc(flush_ev), .clr(cnt_clr), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scoreboard bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;
   import pipe_ctrl_pkg::*;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst, operands_valid, exec_start, exec_done, branch_redirect, trap_req, cnt_clr;
   logic stall_if, stall_id, stall_ex, bubble_mem, flush_id, flush_ex, ld_timeout;
   logic [1:0] ctrl_state;
   logic [CW-1:0] ld_stall_cnt, ex_stall_cnt, flush_cnt;

   typedef struct packed {logic sg; logic fl; logic [1:0] st; logic to;} exp_t;
   exp_t q[$];
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.LD_TIMEOUT(8), .FLUSH_LEN(3), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .operands_valid(operands_valid), .exec_start(exec_start),
      .exec_done(exec_done), .branch_redirect(branch_redirect), .trap_req(trap_req),
      .cnt_clr(cnt_clr), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .bubble_mem(bubble_mem), .flush_id(flush_id), .flush_ex(flush_ex),
      .ctrl_state(ctrl_state), .ld_timeout(ld_timeout), .ld_stall_cnt(ld_stall_cnt),
      .ex_stall_cnt(ex_stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ov, es, ed, br, tr, cc,
                       input logic esg, efl, input logic [1:0] est, input logic eto);
      exp_t e;
      @(negedge clk);
      operands_valid = ov; exec_start = es; exec_done = ed;
      branch_redirect = br; trap_req = tr; cnt_clr = cc;
      q.push_back('{sg: esg, fl: efl, st: est, to: eto});
      #1 e = q.pop_front();
      chk("stall_grp", {stall_if, stall_id, stall_ex, bubble_mem}, {4{e.sg}});
      chk("flush", {flush_id, flush_ex}, {2{e.fl}});
      @(posedge clk);
      #1 chk("state", ctrl_state, e.st);
      chk("ld_timeout", ld_timeout, e.to);
   endtask

   task automatic chk_cnt(input logic [CW-1:0] ld, ex, fl);
      chk("ld_cnt", ld_stall_cnt, ld);
      chk("ex_cnt", ex_stall_cnt, ex);
      chk("fl_cnt", flush_cnt, fl);
   endtask

   initial begin
      rst = 1'b1; operands_valid = 1'b0; exec_start = 1'b1; exec_done = 1'b0;
      branch_redirect = 1'b0; trap_req = 1'b1; cnt_clr = 1'b0;
      @(posedge clk); #1;
      chk("rst_stall", {stall_if, stall_id, stall_ex, bubble_mem}, 4'b0);
      chk("rst_flush", {flush_id, flush_ex}, 2'b0);
      chk("rst_state", ctrl_state, RUN);
      chk("rst_to", ld_timeout, 1'b0);
      chk_cnt(0, 0, 0);
      @(negedge clk); rst = 1'b0; trap_req = 1'b0; exec_start = 1'b0; operands_valid = 1'b1;
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      // load-use for three cycles
      step(0, 0, 0, 0, 0, 0, 1, 0, LD_WAIT, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, LD_WAIT, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, LD_WAIT, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      chk_cnt(3, 0, 0);
      // multicycle op, done four cycles after start, then single-cycle op
      step(1, 1, 0, 0, 0, 0, 1, 0, EX_BUSY, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, EX_BUSY, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, EX_BUSY, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, EX_BUSY, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0, RUN, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, RUN, 0);
      chk_cnt(3, 4, 0);
      // trap during load wait
      step(0, 0, 0, 0, 0, 0, 1, 0, LD_WAIT, 0);
      step(0, 0, 0, 0, 1, 0, 0, 1, FLUSH, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, FLUSH, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, RUN, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      chk_cnt(4, 4, 1);
      // branch ignored while EX_BUSY
      step(1, 1, 0, 0, 0, 0, 1, 0, EX_BUSY, 0);
      step(1, 0, 0, 1, 0, 0, 1, 0, EX_BUSY, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0, RUN, 0);
      // branch flush, then trap inside FLUSH restarts without counting
      step(1, 0, 0, 1, 0, 0, 0, 1, FLUSH, 0);
      step(1, 0, 0, 0, 1, 0, 0, 1, FLUSH, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, FLUSH, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, RUN, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      chk_cnt(4, 6, 2);
      // clear wins over a same-cycle increment
      step(0, 0, 0, 0, 0, 1, 1, 0, LD_WAIT, 0);
      chk_cnt(0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      // 20-cycle load wait: single timeout pulse on the 8th LD_WAIT cycle
      for (int i = 1; i <= 20; i++) step(0, 0, 0, 0, 0, 0, 1, 0, LD_WAIT, i == 8);
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      chk("ld_cnt_wrap20", ld_stall_cnt, 4'd4);
      step(1, 0, 0, 0, 0, 1, 0, 0, RUN, 0);
      for (int i = 1; i <= 17; i++) step(0, 0, 0, 0, 0, 0, 1, 0, LD_WAIT, i == 8);
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      chk("ld_cnt_wrap17", ld_stall_cnt, 4'd1);
      // async reset in the middle of EX_BUSY
      step(1, 1, 0, 0, 0, 0, 1, 0, EX_BUSY, 0);
      @(negedge clk); exec_start = 1'b0; exec_done = 1'b0;
      #1 chk("busy_pre_rst", {stall_if, stall_id, stall_ex, bubble_mem}, 4'hf);
      #1 rst = 1'b1;
      #1 chk("async_stall", {stall_if, stall_id, stall_ex, bubble_mem}, 4'b0);
      chk("async_flush", {flush_id, flush_ex}, 2'b0);
      chk("async_state", ctrl_state, RUN);
      chk_cnt(0, 0, 0);
      @(negedge clk); rst = 1'b0;
      step(1, 0, 0, 0, 0, 0, 0, 0, RUN, 0);
      chk_cnt(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Consumes the operand-valid indication from the EXEC-stage forwarding/hazard unit, the multicycle EXEC handshake, branch redirect and trap requests.
- Produces per-stage stall, bubble and flush controls plus performance counters.
- Sits beside the forwarding unit and drives the IF/ID/EX pipeline-register enables.

Parameters:
- LD_TIMEOUT, 256, cycles in LD_WAIT before ld_timeout pulses (≥2).
- FLUSH_LEN, 1, cycles flush stays asserted per redirect/trap event (≥1).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- operands_valid  in  1  high when EXEC operands are available; low = load-use wait on MEM-stage load data.
- exec_start  in  1  multicycle op issued in EXEC this cycle.
- exec_done  in  1  multicycle op result ready this cycle.
- branch_redirect  in  1  taken branch/jump resolved in EXEC.
- trap_req  in  1  exception/interrupt redirect.
- cnt_clr  in  1  synchronous clear of all counters.
- stall_if  out  1  hold fetch PC/IF register.
- stall_id  out  1  hold ID/EX register.
- stall_ex  out  1  hold EX-stage instruction.
- bubble_mem  out  1  insert NOP into EX/MEM register.
- flush_id  out  1  squash instruction in ID.
- flush_ex  out  1  squash instruction in EX.
- ctrl_state  out  2  current FSM state.
- ld_timeout  out  1  one-cycle pulse, load wait exceeded.
- ld_stall_cnt  out  CNT_W  cycles stalled on load-use.
- ex_stall_cnt  out  CNT_W  cycles stalled on multicycle EXEC.
- flush_cnt  out  CNT_W  number of flush events.

Behaviour:
- Reset (async, rst=1): state RUN, counters 0, ld_timeout 0, flush/wait counters 0. All stall/bubble/flush outputs are forced 0 while rst=1.
- States: RUN=0, LD_WAIT=1, EX_BUSY=2, FLUSH=3.
- Timing: stall_*, bubble_mem, flush_* are combinational (Mealy) from state and inputs, so the stall is taken the same cycle the hazard is seen. All other outputs are registered.
- Stall grouping: "stall group" means stall_if = stall_id = stall_ex = bubble_mem = 1.
- Priority each cycle, in order: trap_req > branch_redirect > ~operands_valid > multicycle busy.
- Flush (trap_req or branch_redirect, any state except FLUSH):
  - flush_id = flush_ex = 1 this cycle; stall group = 0.
  - flush_cnt += 1.
  - Next state is FLUSH if FLUSH_LEN > 1, else RUN.
  - Any load wait or EXEC wait is abandoned and the wait counter cleared.
- FLUSH state:
  - flush_id = flush_ex = 1 for FLUSH_LEN−1 further cycles, then RUN.
  - New trap_req in FLUSH restarts the count but does not increment flush_cnt; branch_redirect is ignored.
- RUN:
  - ~operands_valid: stall group = 1; ld_stall_cnt += 1; go LD_WAIT.
  - Else exec_start & ~exec_done: stall group = 1; ex_stall_cnt += 1; go EX_BUSY.
  - exec_start & exec_done in the same cycle: no stall, stay RUN.
- LD_WAIT:
  - While ~operands_valid: stall group = 1, ld_stall_cnt += 1, wait counter += 1.
  - operands_valid = 1: stall group = 0 the same cycle; go RUN, or EX_BUSY if exec_start & ~exec_done.
- Timeout:
  - When the wait counter reaches LD_TIMEOUT−1, ld_timeout pulses for exactly one cycle (registered).
  - The wait counter then saturates; no further pulse in the same wait episode. State remains LD_WAIT.
- EX_BUSY:
  - Stall group = 1 and ex_stall_cnt += 1 on every cycle with exec_done = 0.
  - exec_done = 1: stall group = 0 the same cycle; go RUN.
  - exec_start in EX_BUSY is ignored. branch_redirect in EX_BUSY is ignored; only trap_req preempts.
- Counters:
  - Wrap modulo 2^CNT_W.
  - cnt_clr has priority over a same-cycle increment: the result is 0.
- Reset mid-stall: outputs drop immediately (async); after rst deasserts the FSM starts in RUN.

Decomposition:
- Package pipe_ctrl_pkg: state encodings (RUN/LD_WAIT/EX_BUSY/FLUSH) and the stall-group bit positions.
- One sub-module, perf_counter (CNT_W-wide, inc/clr, async reset, wrap), instantiated three times.
- Wait counter and flush counter stay inline.

Test Plan:
- Load-use: operands_valid low for 3 cycles from RUN → stall group = 1 for exactly those 3 cycles; ld_stall_cnt = 3; state 0→1→1→1→0; no ld_timeout.
- Multicycle: exec_start with exec_done 4 cycles later → stall group = 1 for 4 cycles, 0 on the done cycle; ex_stall_cnt = 4. Single-cycle variant (start and done same cycle) → no stall.
- Flush priority: trap_req during LD_WAIT with operands_valid low, FLUSH_LEN = 3 → flush_id/flush_ex = 1 for 3 cycles; stall group = 0 on all of them; flush_cnt = 1; state returns to RUN.
- Timeout: LD_TIMEOUT = 8, operands_valid held low 20 cycles → ld_timeout high for exactly 1 cycle, the 8th cycle after entering LD_WAIT; ld_stall_cnt = 20.
- Counter edges: CNT_W = 4, 17 load-stall cycles → ld_stall_cnt = 1 (wrapped). cnt_clr asserted on an increment cycle → 0 next cycle.
- Async reset: assert rst mid-EX_BUSY, off clock edge → all outputs 0 immediately; after release, ctrl_state = 0 and counters = 0.
